// File: rtl/seatbelt_chime_ctrl.sv
// Seat-belt warning sequencer: qualifies the registered door/ignition/belt
// condition, then plays a bounded beep pattern followed by a steady lamp.
module seatbelt_chime_ctrl #(
  parameter int unsigned DLY   = 4,
  parameter int unsigned ON    = 3,
  parameter int unsigned OFF   = 2,
  parameter int unsigned NBEEP = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       door_close,
  input  logic       ignition,
  input  logic       seat_belt,
  input  logic       mute,
  output logic       alarm,
  output logic       lamp,
  output logic [1:0] state
);

  localparam int unsigned DW = $clog2(DLY + 1);
  localparam int unsigned PW = $clog2(ON + OFF + 1);
  localparam int unsigned BW = $clog2(NBEEP + 1);

  localparam logic [DW-1:0] DLY_LAST  = DW'(DLY - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(ON + OFF - 1);
  localparam logic [PW-1:0] ON_LIM    = PW'(ON);
  localparam logic [BW-1:0] BEEP_LAST = BW'(NBEEP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CHIME = 2'd2,
    ST_LAMP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          door_q, ign_q, belt_q;
  logic          warn_q;
  logic          alarm_d, lamp_d;

  // Switch inputs are sampled once; the warning term is built from the samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_q <= 1'b0;
      ign_q  <= 1'b0;
      belt_q <= 1'b0;
    end else begin
      door_q <= door_close;
      ign_q  <= ignition;
      belt_q <= seat_belt;
    end
  end

  assign warn_q = door_q & ign_q & ~belt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
      bcnt_q  <= '0;
      alarm   <= 1'b0;
      lamp    <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
      bcnt_q  <= bcnt_d;
      alarm   <= alarm_d;
      lamp    <= lamp_d;
    end
  end

  // Next state and counters; loss of the warning condition overrides everything.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;
    bcnt_d  = bcnt_q;

    if (state_q != ST_IDLE && !warn_q) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (warn_q) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (dcnt_q == DLY_LAST) state_d = ST_CHIME;
          else                    dcnt_d  = dcnt_q + DW'(1);
        end
        ST_CHIME: begin
          if (mute) begin
            state_d = ST_LAMP;
          end else if (pcnt_q == PH_LAST) begin
            if (bcnt_q == BEEP_LAST) begin
              state_d = ST_LAMP;
            end else begin
              pcnt_d = '0;
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        ST_LAMP: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Every state change starts the new state with fresh counters.
    if (state_d != state_q) begin
      dcnt_d = '0;
      pcnt_d = '0;
      bcnt_d = '0;
    end

    alarm_d = (state_d == ST_CHIME) && (pcnt_d < ON_LIM);
    lamp_d  = (state_d == ST_CHIME) || (state_d == ST_LAMP);
  end

  assign state = state_q;

endmodule

// File: tb/tb_seatbelt_chime_ctrl.sv
// Directed bench for seatbelt_chime_ctrl: default instance plus a minimum-
// parameter instance (all parameters 1) sharing the same stimulus.
module tb_seatbelt_chime_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       door_close = 1'b0;
  logic       ignition = 1'b0;
  logic       seat_belt = 1'b0;
  logic       mute = 1'b0;
  logic       alarm, lamp;
  logic [1:0] state;
  logic       alarm_m, lamp_m;
  logic [1:0] state_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seatbelt_chime_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .door_close(door_close), .ignition(ignition),
    .seat_belt(seat_belt), .mute(mute), .alarm(alarm), .lamp(lamp), .state(state)
  );

  seatbelt_chime_ctrl #(.DLY(1), .ON(1), .OFF(1), .NBEEP(1)) u_dut_min (
    .clk(clk), .rst_n(rst_n), .door_close(door_close), .ignition(ignition),
    .seat_belt(seat_belt), .mute(mute), .alarm(alarm_m), .lamp(lamp_m), .state(state_m)
  );

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    door_close = 1'b0; ignition = 1'b0; seat_belt = 1'b0; mute = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({state, alarm, lamp} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset: state/alarm/lamp got %b want 0000", {state, alarm, lamp});
    end
    n_vec++;
    if ({state_m, alarm_m, lamp_m} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_min: state/alarm/lamp got %b want 0000", {state_m, alarm_m, lamp_m});
    end
  endtask

  // Hold the warning condition; check both instances edge by edge from E1.
  task automatic test_nominal();
    logic       ea, el, ea_m, el_m;
    logic [1:0] es, es_m;
    do_reset();
    door_close = 1'b1; ignition = 1'b1; seat_belt = 1'b0;
    step(1); // E0
    for (int k = 1; k <= 22; k++) begin
      step(1);
      ea   = (k >= 5) && (k <= 19) && (((k - 5) % 5) < 3);
      el   = (k >= 5);
      es   = (k < 5) ? 2'd1 : (k < 20) ? 2'd2 : 2'd3;
      ea_m = (k == 2);
      el_m = (k >= 2);
      es_m = (k == 1) ? 2'd1 : (k < 4) ? 2'd2 : 2'd3;
      n_vec++;
      if (alarm !== ea) begin
        n_err++; $display("FAIL nominal alarm E%0d: got %b want %b", k, alarm, ea);
      end
      n_vec++;
      if (lamp !== el) begin
        n_err++; $display("FAIL nominal lamp E%0d: got %b want %b", k, lamp, el);
      end
      n_vec++;
      if (state !== es) begin
        n_err++; $display("FAIL nominal state E%0d: got %0d want %0d", k, state, es);
      end
      n_vec++;
      if ({state_m, alarm_m, lamp_m} !== {es_m, ea_m, el_m}) begin
        n_err++;
        $display("FAIL min_params E%0d: state/alarm/lamp got %b want %b",
                 k, {state_m, alarm_m, lamp_m}, {es_m, ea_m, el_m});
      end
    end
  endtask

  task automatic test_belt_buckle();
    do_reset();
    door_close = 1'b1; ignition = 1'b1; seat_belt = 1'b0;
    step(1);  // E0
    step(10); // E10
    seat_belt = 1'b1;
    step(1);  // E11: drop sampled, still chiming
    n_vec++;
    if (state !== 2'd2) begin
      n_err++; $display("FAIL buckle state E11: got %0d want 2", state);
    end
    step(1);  // E12
    n_vec++;
    if ({state, alarm, lamp} !== 4'b0000) begin
      n_err++; $display("FAIL buckle E12: state/alarm/lamp got %b want 0000", {state, alarm, lamp});
    end
  endtask

  task automatic test_mute();
    do_reset();
    door_close = 1'b1; ignition = 1'b1; seat_belt = 1'b0;
    step(1);  // E0
    step(5);  // E5
    mute = 1'b1;
    step(1);  // E6
    mute = 1'b0;
    n_vec++;
    if ({state, alarm, lamp} !== 4'b1101) begin
      n_err++; $display("FAIL mute E6: state/alarm/lamp got %b want 1101", {state, alarm, lamp});
    end
    for (int k = 7; k <= 26; k++) begin
      step(1);
      n_vec++;
      if ({state, alarm, lamp} !== 4'b1101) begin
        n_err++;
        $display("FAIL mute_hold E%0d: state/alarm/lamp got %b want 1101", k, {state, alarm, lamp});
      end
    end
  endtask

  task automatic test_mute_vs_drop();
    do_reset();
    door_close = 1'b1; ignition = 1'b1; seat_belt = 1'b0;
    step(1);  // E0
    step(6);  // E6
    seat_belt = 1'b1;
    step(1);  // E7: drop sampled
    mute = 1'b1;
    step(1);  // E8: drop and mute together
    mute = 1'b0;
    n_vec++;
    if ({state, alarm, lamp} !== 4'b0000) begin
      n_err++; $display("FAIL mute_vs_drop E8: state/alarm/lamp got %b want 0000", {state, alarm, lamp});
    end
  endtask

  task automatic test_door_open();
    do_reset();
    door_close = 1'b0; ignition = 1'b1; seat_belt = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      n_vec++;
      if ({state, alarm, lamp} !== 4'b0000) begin
        n_err++;
        $display("FAIL door_open cycle %0d: state/alarm/lamp got %b want 0000", k, {state, alarm, lamp});
      end
    end
  endtask

  // Ignition glitch in ARMED: IDLE at E4, warn_q back at E4, alarm at E4+DLY+1.
  task automatic test_ignition_glitch();
    logic       ea;
    logic [1:0] es;
    do_reset();
    door_close = 1'b1; ignition = 1'b1; seat_belt = 1'b0;
    step(1);  // E0
    step(2);  // E2
    ignition = 1'b0;
    step(1);  // E3
    ignition = 1'b1;
    n_vec++;
    if (state !== 2'd1) begin
      n_err++; $display("FAIL glitch state E3: got %0d want 1", state);
    end
    for (int k = 4; k <= 10; k++) begin
      step(1);
      es = (k == 4) ? 2'd0 : (k < 9) ? 2'd1 : 2'd2;
      ea = (k >= 9);
      n_vec++;
      if ({state, alarm} !== {es, ea}) begin
        n_err++;
        $display("FAIL glitch E%0d: state/alarm got %b want %b", k, {state, alarm}, {es, ea});
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    door_close = 1'b1; ignition = 1'b1; seat_belt = 1'b0;
    step(1);  // E0
    step(6);  // E6: beep 1 high
    n_vec++;
    if ({state, alarm, lamp} !== 4'b1011) begin
      n_err++; $display("FAIL areset pre E6: state/alarm/lamp got %b want 1011", {state, alarm, lamp});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state, alarm, lamp} !== 4'b0000) begin
      n_err++; $display("FAIL areset mid-cycle: state/alarm/lamp got %b want 0000", {state, alarm, lamp});
    end
    step(1);
    rst_n = 1'b1;
    step(1);  // E0 of restarted sequence
    step(4);  // E4
    n_vec++;
    if ({state, alarm, lamp} !== 4'b0100) begin
      n_err++; $display("FAIL areset restart E4: state/alarm/lamp got %b want 0100", {state, alarm, lamp});
    end
    step(1);  // E5
    n_vec++;
    if ({state, alarm, lamp} !== 4'b1011) begin
      n_err++; $display("FAIL areset restart E5: state/alarm/lamp got %b want 1011", {state, alarm, lamp});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_belt_buckle();
    test_mute();
    test_mute_vs_drop();
    test_door_open();
    test_ignition_glitch();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seatbelt_chime_ctrl.md
# seatbelt_chime_ctrl

Sequencing controller for the seat-belt warning path. It qualifies the door-closed / ignition-on / belt-unbuckled condition over time, then drives a bounded beep pattern on the audible alarm followed by a steady warning lamp. The block sits between the raw cabin-switch inputs and the alarm/lamp drivers. It is the clocked counterpart of the combinational `carWarning` condition.

## Interface
- `DLY`, default 4: cycles the warning condition must persist in ARMED before chiming; ≥1.
- `ON`, default 3: cycles `alarm` is high per beep; ≥1.
- `OFF`, default 2: cycles `alarm` is low after each beep; ≥1.
- `NBEEP`, default 3: number of beeps before falling back to lamp-only; ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `door_close`  in  1  1 = door closed; synchronous to `clk`.
- `ignition`  in  1  1 = ignition on; synchronous to `clk`.
- `seat_belt`  in  1  1 = belt buckled; synchronous to `clk`.
- `mute`  in  1  single-cycle driver acknowledge; silences the chime early.
- `alarm`  out  1  audible beep drive, registered.
- `lamp`  out  1  warning lamp drive, registered.
- `state`  out  2  current state: IDLE=0, ARMED=1, CHIME=2, LAMP=3.

## Operation
- The three switch inputs are registered once. The registered condition is `warn_q = door_close & ignition & ~seat_belt`.
- `mute` is used unregistered.
- Counters:
  - `dcnt` has width $clog2(DLY+1).
  - `pcnt` is the phase counter, width $clog2(ON+OFF+1).
  - `bcnt` is the beep counter, width $clog2(NBEEP+1).
  - All counters clear on every state change.
- Transitions, in priority order:
  - Any non-IDLE state with `warn_q`=0: go to IDLE at the next edge.
  - IDLE with `warn_q`=1: go to ARMED and set `dcnt`=0.
  - ARMED: `dcnt` increments each edge. At the edge where `dcnt`==DLY-1, go to CHIME.
  - CHIME with `mute`=1: go to LAMP.
  - CHIME otherwise:
    - `pcnt` counts 0..ON+OFF-1 and wraps to 0.
    - `bcnt` increments on each wrap.
    - At the edge where `pcnt`==ON+OFF-1 and `bcnt`==NBEEP-1, go to LAMP.
  - LAMP: stay while `warn_q`=1.
- Outputs are registered from next-state/next-counter values, so they change on the same edge as the state:
  - `alarm`=1 only in CHIME while the next `pcnt` < ON.
  - `lamp`=1 in CHIME and LAMP.
  - Both outputs are 0 in IDLE and ARMED.
- `mute` in IDLE, ARMED or LAMP: ignored.
- Re-arm: a belt buckle/unbuckle or ignition cycle passes through IDLE and restarts the full sequence from ARMED. No beep history is retained.
- Reset: `state`=IDLE, all counters 0, `alarm`=0, `lamp`=0, input registers 0. Reset asserted mid-CHIME silences `alarm` immediately, without waiting for a clock edge.

## Timing
- Notation: E0 is the edge where `warn_q` first becomes 1. Inputs are stable before E0.
- ARMED entered at E1. CHIME entered, `alarm`↑ and `lamp`↑ at E(DLY+1).
- Each beep: `alarm` high ON cycles, then low OFF cycles.
- CHIME lasts exactly NBEEP·(ON+OFF) cycles. LAMP entered at E(DLY+1+NBEEP·(ON+OFF)).
- Warning removal: an input drop sampled into `warn_q` at edge Ek gives IDLE, `alarm`=0, `lamp`=0 at Ek+1. That is 2 edges from the input change.
- `mute` high in the cycle before edge Em while in CHIME: LAMP and `alarm`=0 at Em; `lamp` stays 1.
- `warn_q`=0 and `mute`=1 on the same edge: IDLE wins.
- DLY=1: ARMED lasts one cycle.
- `warn_q` dropping for a single cycle in ARMED restarts qualification from IDLE.

## Test plan
- Defaults; drive `door_close`=1, `ignition`=1, `seat_belt`=0 and hold.
  - Required: `alarm` = 1,1,1,0,0 repeated 3 times, starting at E5.
  - Required: `lamp`=1 from E5; `state`=3 from E20 with `alarm`=0.
- Same stimulus, then `seat_belt`=1 at E10 (mid-beep 2).
  - Required: `alarm`=0, `lamp`=0, `state`=0 at E12.
- Same stimulus, with a single-cycle `mute` during beep 1 high phase, captured at E6.
  - Required: `state`=3, `alarm`=0, `lamp`=1 at E6.
  - Required: no further beeps.
- `door_close`=0, `ignition`=1, `seat_belt`=0 for 50 cycles.
  - Required: `state`=0, `alarm`=0, `lamp`=0 throughout.
- Condition held, `ignition` pulsed low for 1 cycle during ARMED.
  - Required: return to IDLE, then a fresh ARMED.
  - Required: first `alarm`↑ occurs DLY+1 edges after `warn_q` re-rises.
- `rst_n` pulsed low asynchronously mid-CHIME.
  - Required: `alarm`, `lamp` and `state` go to 0 before the next edge.
  - Required: after release, the sequence restarts normally.
